// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam word_t NOP_WORD         = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch addresses are always word aligned; low bits of a target are ignored.
  function automatic word_t align_word(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: fetch unit is master, memory is slave.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Next-fetch PC register with redirect/advance mux and +4 adder; updates one edge after request.
// No backpressure of its own: redirect beats advance, reset beats both.
module fetch_pc_reg
  import if_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  redirect,
  input  word_t redirect_addr,
  input  logic  advance,
  input  word_t base_addr,
  output word_t pc_reg,
  output word_t base_plus4
);

  assign base_plus4 = base_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (redirect) begin
      pc_reg <= align_word(redirect_addr);
    end else if (advance) begin
      pc_reg <= base_plus4;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch into IF/ID: one outstanding imem read, word presented the cycle after ack (1 instr / 2 cycles).
// Word is held until load_enable; branch_taken flushes and redirects, dropping any in-flight data.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_enable,
  input  logic            branch_taken,
  input  word_t           target_addr,
  if_fetch_unit_if.master imem,
  output word_t           instruction,
  output word_t           pc,
  output word_t           if_pc_plus4,
  output logic            hazard_reset
);

  fetch_state_t state, state_d;
  word_t        req_addr, req_addr_d;
  logic         discard, discard_d;
  word_t        instr_q, instr_d;
  word_t        pc_q, pc_d;
  word_t        pc4_q, pc4_d;
  logic         redirect, advance;
  word_t        pc_reg, req_plus4;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_addr (target_addr),
    .advance       (advance),
    .base_addr     (req_addr),
    .pc_reg        (pc_reg),
    .base_plus4    (req_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
      instr_q  <= NOP_WORD;
      pc_q     <= NOP_WORD;
      pc4_q    <= NOP_WORD;
    end else begin
      state    <= state_d;
      req_addr <= req_addr_d;
      discard  <= discard_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
    end
  end

  always_comb begin
    state_d    = state;
    req_addr_d = req_addr;
    discard_d  = discard;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    redirect   = branch_taken;
    advance    = 1'b0;

    if (branch_taken) begin
      // With a read still outstanding the address must stay put, so only remember to drop its data.
      if (state == ST_WAIT && !imem.imem_ack) begin
        discard_d = 1'b1;
      end else begin
        state_d    = ST_WAIT;
        req_addr_d = align_word(target_addr);
        discard_d  = 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          req_addr_d = pc_reg;
        end
        ST_WAIT: begin
          if (imem.imem_ack) begin
            if (discard) begin
              discard_d  = 1'b0;
              req_addr_d = pc_reg;
            end else begin
              instr_d = imem.imem_data;
              pc_d    = req_addr;
              pc4_d   = req_plus4;
              advance = 1'b1;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (load_enable) begin
            state_d    = ST_WAIT;
            req_addr_d = pc_reg;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (state == ST_WAIT);
  assign imem.imem_addr = req_addr;

  assign instruction  = (state == ST_HOLD) ? instr_q : NOP_WORD;
  assign pc           = (state == ST_HOLD) ? pc_q    : NOP_WORD;
  assign if_pc_plus4  = (state == ST_HOLD) ? pc4_q   : NOP_WORD;
  assign hazard_reset = branch_taken & ~reset;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a program-order fetch model.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset, load_enable, branch_taken;
  logic [31:0] target_addr, instruction, pc, if_pc_plus4;
  logic        hazard_reset;
  logic        reset2, load2, branch2;
  logic [31:0] target2, instr2, pc2, pc4_2;
  logic        hazard2;
  int          n_checks;
  int          n_errors;

  if_fetch_unit_if bus ();
  if_fetch_unit_if bus2 ();

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .load_enable  (load_enable),
    .branch_taken (branch_taken),
    .target_addr  (target_addr),
    .imem         (bus),
    .instruction  (instruction),
    .pc           (pc),
    .if_pc_plus4  (if_pc_plus4),
    .hazard_reset (hazard_reset)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk          (clk),
    .reset        (reset2),
    .load_enable  (load2),
    .branch_taken (branch2),
    .target_addr  (target2),
    .imem         (bus2),
    .instruction  (instr2),
    .pc           (pc2),
    .if_pc_plus4  (pc4_2),
    .hazard_reset (hazard2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a bijective scramble of the address, so every word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; branch_taken = 1'b0; load_enable = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; branch_taken = 1'b1; target_addr = 32'h0000_0ABC;
    bus.imem_ack = 1'b1; bus.imem_data = 32'hCAFE_F00D; load_enable = 1'b1;
    tick(); tick();
    n_checks++; if ({instruction, pc, if_pc_plus4} !== 96'h0) begin n_errors++; $display("FAIL reset_outputs: got %h %h %h want zeros", instruction, pc, if_pc_plus4); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_checks++; if (hazard_reset !== 1'b0) begin n_errors++; $display("FAIL reset_hazard: got %b want 0", hazard_reset); end
    branch_taken = 1'b0; bus.imem_ack = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    load_enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (bus.imem_req !== ((k % 2) == 1)) begin n_errors++; $display("FAIL zw_req k=%0d: got %b want %b", k, bus.imem_req, (k % 2) == 1); end
      if (k >= 2 && (k % 2) == 0) begin
        exp_pc = 32'(4 * (k / 2 - 1));
        n_checks++; if ({pc, instruction, if_pc_plus4} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin n_errors++; $display("FAIL zw_hold k=%0d: got pc=%h ins=%h p4=%h want pc=%h", k, pc, instruction, if_pc_plus4, exp_pc); end
      end else begin
        n_checks++; if ({instruction, pc, if_pc_plus4} !== 96'h0) begin n_errors++; $display("FAIL zw_nop k=%0d: got %h %h %h want zeros", k, instruction, pc, if_pc_plus4); end
      end
      bus.imem_ack  = bus.imem_req;
      bus.imem_data = mem_word(bus.imem_addr);
      if (k == 6) load_enable = 1'b0;
      tick();
    end
  endtask

  // Entered straight after test_zero_wait: held at pc=8 with load_enable low.
  task automatic test_stall();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({bus.imem_req, pc, instruction, if_pc_plus4} !== {1'b0, 32'h8, mem_word(32'h8), 32'hC}) begin n_errors++; $display("FAIL stall_hold i=%0d: got req=%b pc=%h ins=%h p4=%h want pc=8", i, bus.imem_req, pc, instruction, if_pc_plus4); end
      if (i == 3) load_enable = 1'b1;
      tick();
    end
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hC}) begin n_errors++; $display("FAIL stall_resume: got req=%b addr=%h want 1 0000000c", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_data = mem_word(32'hC);
    tick();
    n_checks++; if ({pc, instruction} !== {32'hC, mem_word(32'hC)}) begin n_errors++; $display("FAIL stall_next: got pc=%h ins=%h want pc=0000000c", pc, instruction); end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    load_enable = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin
      n_checks++; if ({bus.imem_req, bus.imem_addr, pc, instruction} !== {1'b1, 96'h0}) begin n_errors++; $display("FAIL dly_wait w=%0d: got req=%b addr=%h pc=%h ins=%h want 1 0 0 0", w, bus.imem_req, bus.imem_addr, pc, instruction); end
      bus.imem_ack  = (w == 3);
      bus.imem_data = (w == 3) ? mem_word(32'h0) : 32'hDEAD_BEEF;
      tick();
    end
    bus.imem_ack = 1'b0;
    n_checks++; if ({bus.imem_req, pc, instruction, if_pc_plus4} !== {1'b0, 32'h0, mem_word(32'h0), 32'h4}) begin n_errors++; $display("FAIL dly_hold: got req=%b pc=%h ins=%h p4=%h", bus.imem_req, pc, instruction, if_pc_plus4); end
  endtask

  task automatic test_branch_discard();
    do_reset();
    load_enable = 1'b1;
    tick();
    bus.imem_ack = 1'b1; bus.imem_data = mem_word(32'h0);
    tick();
    bus.imem_ack = 1'b0;
    tick();
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin n_errors++; $display("FAIL br_pre: got req=%b addr=%h want 1 00000004", bus.imem_req, bus.imem_addr); end
    branch_taken = 1'b1; target_addr = 32'h100;
    #1;
    n_checks++; if (hazard_reset !== 1'b1) begin n_errors++; $display("FAIL br_hazard: got %b want 1", hazard_reset); end
    tick();
    branch_taken = 1'b0;
    n_checks++; if ({bus.imem_req, bus.imem_addr, instruction} !== {1'b1, 32'h4, 32'h0}) begin n_errors++; $display("FAIL br_addr_kept: got req=%b addr=%h ins=%h", bus.imem_req, bus.imem_addr, instruction); end
    bus.imem_ack = 1'b1; bus.imem_data = mem_word(32'h4);
    tick();
    n_checks++; if ({bus.imem_req, bus.imem_addr, pc, instruction} !== {1'b1, 32'h100, 64'h0}) begin n_errors++; $display("FAIL br_late_drop: got req=%b addr=%h pc=%h ins=%h", bus.imem_req, bus.imem_addr, pc, instruction); end
    bus.imem_data = mem_word(32'h100);
    tick();
    n_checks++; if ({pc, instruction, if_pc_plus4} !== {32'h100, mem_word(32'h100), 32'h104}) begin n_errors++; $display("FAIL br_target: got pc=%h ins=%h p4=%h want pc=00000100", pc, instruction, if_pc_plus4); end
    bus.imem_ack = 1'b0; branch_taken = 1'b1; target_addr = 32'h103;
    tick();
    branch_taken = 1'b0;
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin n_errors++; $display("FAIL br_align: got req=%b addr=%h want 1 00000100", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_data = mem_word(32'h100);
    branch_taken = 1'b1; target_addr = 32'h200;
    tick();
    branch_taken = 1'b0; bus.imem_ack = 1'b0;
    n_checks++; if ({bus.imem_req, bus.imem_addr, instruction} !== {1'b1, 32'h200, 32'h0}) begin n_errors++; $display("FAIL br_ack_same: got req=%b addr=%h ins=%h want 1 00000200 0", bus.imem_req, bus.imem_addr, instruction); end
  endtask

  task automatic test_newest_target();
    do_reset();
    load_enable = 1'b1;
    tick();
    branch_taken = 1'b1; target_addr = 32'h40;
    tick();
    target_addr = 32'h80;
    tick();
    branch_taken = 1'b0;
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL nt_pending: got req=%b addr=%h want 1 0", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_data = mem_word(32'h0);
    tick();
    n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h80}) begin n_errors++; $display("FAIL nt_refetch: got req=%b addr=%h want 1 00000080", bus.imem_req, bus.imem_addr); end
    bus.imem_data = mem_word(32'h80);
    tick();
    bus.imem_ack = 1'b0;
    n_checks++; if ({pc, instruction} !== {32'h80, mem_word(32'h80)}) begin n_errors++; $display("FAIL nt_present: got pc=%h ins=%h want pc=00000080", pc, instruction); end
  endtask

  task automatic test_wrap_and_reset();
    reset2 = 1'b1; tick(); tick();
    reset2 = 1'b0; load2 = 1'b1;
    tick();
    n_checks++; if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_errors++; $display("FAIL wrap_first: got req=%b addr=%h want 1 fffffffc", bus2.imem_req, bus2.imem_addr); end
    bus2.imem_ack = 1'b1; bus2.imem_data = mem_word(32'hFFFF_FFFC);
    tick();
    bus2.imem_ack = 1'b0;
    n_checks++; if ({pc2, instr2, pc4_2} !== {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0}) begin n_errors++; $display("FAIL wrap_plus4: got pc=%h ins=%h p4=%h want p4=0", pc2, instr2, pc4_2); end
    tick();
    n_checks++; if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL wrap_next: got req=%b addr=%h want 1 0", bus2.imem_req, bus2.imem_addr); end
    reset2 = 1'b1; branch2 = 1'b1; target2 = 32'h500;
    bus2.imem_ack = 1'b1; bus2.imem_data = 32'h0000_0123;
    tick();
    n_checks++; if ({bus2.imem_req, pc2, instr2, pc4_2, hazard2} !== {1'b0, 96'h0, 1'b0}) begin n_errors++; $display("FAIL rst_mid: got req=%b pc=%h ins=%h p4=%h hz=%b", bus2.imem_req, pc2, instr2, pc4_2, hazard2); end
    reset2 = 1'b0; branch2 = 1'b0; bus2.imem_data = 32'h0000_0BAD;
    tick();
    n_checks++; if ({bus2.imem_req, bus2.imem_addr, instr2} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin n_errors++; $display("FAIL rst_restart: got req=%b addr=%h ins=%h", bus2.imem_req, bus2.imem_addr, instr2); end
    bus2.imem_data = mem_word(32'hFFFF_FFFC);
    tick();
    bus2.imem_ack = 1'b0;
    n_checks++; if ({pc2, instr2} !== {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}) begin n_errors++; $display("FAIL rst_refetch: got pc=%h ins=%h", pc2, instr2); end
  endtask

  // Model: presented words follow program order (pc+4 after each consume), restarting at the latest branch target.
  task automatic test_random();
    logic [31:0] exp_pc, mem_addr, tgt;
    bit          pending, br, presented;
    int          wait_left, n_present;
    do_reset();
    exp_pc = 32'h0; pending = 1'b0; wait_left = 0; n_present = 0; mem_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pending) begin
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, mem_addr}) begin n_errors++; $display("FAIL rnd_addr_stable cyc=%0d: got req=%b addr=%h want 1 %h", cyc, bus.imem_req, bus.imem_addr, mem_addr); end
      end
      presented = (cyc > 0) && (bus.imem_req === 1'b0);
      if (presented) begin
        n_present++;
        n_checks++; if ({pc, instruction, if_pc_plus4} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin n_errors++; $display("FAIL rnd_word cyc=%0d: got pc=%h ins=%h p4=%h want pc=%h ins=%h", cyc, pc, instruction, if_pc_plus4, exp_pc, mem_word(exp_pc)); end
      end else begin
        n_checks++; if ({instruction, pc, if_pc_plus4} !== 96'h0) begin n_errors++; $display("FAIL rnd_nop cyc=%0d: got %h %h %h want zeros", cyc, instruction, pc, if_pc_plus4); end
      end
      br = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      branch_taken = br; target_addr = tgt;
      load_enable = ($urandom_range(0, 9) < 7);
      if (bus.imem_req === 1'b1 && !pending) begin
        pending = 1'b1; mem_addr = bus.imem_addr; wait_left = $urandom_range(0, 3);
      end
      bus.imem_ack  = pending && (wait_left == 0);
      bus.imem_data = bus.imem_ack ? mem_word(mem_addr) : $urandom;
      #1;
      n_checks++; if (hazard_reset !== br) begin n_errors++; $display("FAIL rnd_hazard cyc=%0d: got %b want %b", cyc, hazard_reset, br); end
      if (br) exp_pc = tgt & 32'hFFFF_FFFC;
      else if (presented && load_enable) exp_pc = exp_pc + 32'd4;
      if (bus.imem_ack) pending = 1'b0;
      else if (pending) wait_left--;
      tick();
    end
    branch_taken = 1'b0; bus.imem_ack = 1'b0;
    n_checks++; if (n_present < 100) begin n_errors++; $display("FAIL rnd_progress: got %0d presented cycles want at least 100", n_present); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; load_enable = 1'b0; branch_taken = 1'b0; target_addr = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
    reset2 = 1'b1; load2 = 1'b0; branch2 = 1'b0; target2 = 32'h0;
    bus2.imem_ack = 1'b0; bus2.imem_data = 32'h0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_delayed_ack();
    test_branch_discard();
    test_newest_target();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-004 The block SHALL have port load_enable, input, width 1: IF/ID accepts on this edge; 0 means the pipeline is stalled.
REQ-005 The block SHALL have port branch_taken, input, width 1: single-cycle redirect request.
REQ-006 The block SHALL have port target_addr, input, width 32: redirect address, valid when branch_taken=1.
REQ-007 The block SHALL have port imem_req, output, width 1: instruction-memory read request.
REQ-008 The block SHALL have port imem_addr, output, width 32: read address, valid while imem_req=1.
REQ-009 The block SHALL have port imem_ack, input, width 1: imem_data valid this cycle.
REQ-010 The block SHALL have port imem_data, input, width 32: fetched word.
REQ-011 The block SHALL have port instruction, output, width 32: word presented to IF/ID.
REQ-012 The block SHALL have port pc, output, width 32: address of instruction.
REQ-013 The block SHALL have port if_pc_plus4, output, width 32: pc+4.
REQ-014 The block SHALL have port hazard_reset, output, width 1: flush request to IF/ID.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and HOLD, plus a discard flag and an internal pc_reg.
REQ-016 IDLE SHALL go to WAIT unconditionally on the next edge.
REQ-017 In WAIT, imem_req SHALL be 1 and imem_addr SHALL equal the captured request address, held stable until imem_ack.
REQ-018 In WAIT with imem_ack=1 and discard=0, the block SHALL register imem_data, request address and address+4 onto instruction/pc/if_pc_plus4, set pc_reg to address+4, and go to HOLD.
REQ-019 HOLD SHALL hold its outputs stable; on load_enable=1 the word is consumed and the FSM SHALL go to WAIT at pc_reg; on load_enable=0 it SHALL stay in HOLD.
REQ-020 Outside HOLD, instruction, pc and if_pc_plus4 SHALL read 32'h0 (NOP bubble).
REQ-021 Throughput SHALL be 1 instruction per 2 cycles with a zero-wait memory (ack in the first WAIT cycle).
REQ-022 hazard_reset SHALL equal branch_taken combinationally, in the same cycle.
REQ-023 branch_taken SHALL have priority over all events except reset, and SHALL set pc_reg to {target_addr[31:2],2'b00}.
REQ-024 branch_taken in HOLD SHALL drop the held word and go to WAIT at the target.
REQ-025 branch_taken in WAIT with imem_ack=1 SHALL drop imem_data and issue at the target on the next cycle.
REQ-026 branch_taken in WAIT with imem_ack=0 SHALL set discard, keep imem_addr unchanged, drop the data on the later ack, clear discard, and re-enter WAIT at pc_reg.
REQ-027 A repeated branch_taken while discard=1 SHALL overwrite pc_reg, so the newest target wins.
REQ-028 Address arithmetic SHALL be modulo 2^32, e.g. 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-029 reset=1 SHALL force: state IDLE, pc_reg=RESET_PC, discard=0, instruction/pc/if_pc_plus4=0, imem_req=0.
REQ-030 reset SHALL override a simultaneous branch_taken and imem_ack, and any in-flight ack arriving after reset SHALL be ignored.
REQ-031 hazard_reset SHALL be 0 while reset=1.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, the NOP constant (32'h0) and the RESET_PC default.
REQ-033 The block SHALL have one sub-module, fetch_pc_reg: pc_reg with redirect/advance mux and +4 adder.

Verification
REQ-034 Scenario: reset then zero-wait memory, RESET_PC=0, load_enable=1 -> pc sequence 0,4,8 in HOLD on every second cycle, with data matching the memory model.
REQ-035 Scenario: memory ack delayed 3 cycles -> imem_addr is stable for 3 cycles, outputs are NOP meanwhile, and HOLD is entered on the ack edge +1.
REQ-036 Scenario: stall, load_enable=0 for 4 cycles in HOLD at pc=8 -> outputs unchanged and imem_req=0, then fetch at 12 resumes.
REQ-037 Scenario: branch_taken, target 32'h100, during WAIT with ack pending -> hazard_reset=1 that cycle, the late word is dropped, and the next pc presented is 32'h100; also target 32'h103 -> imem_addr 32'h100.
REQ-038 Scenario: branches to 32'h40 then 32'h80 on consecutive cycles while discard -> only 32'h80 is fetched.
REQ-039 Scenario: RESET_PC=32'hFFFF_FFFC -> if_pc_plus4=0, next pc=0; reset asserted mid-WAIT -> outputs 0, fetch restarts at RESET_PC.
